// File: rtl/iter_shift_right.sv
// Multi-cycle right shifter (SRL/SRA) with a start/done handshake.
// Shifts up to STEP bit positions per cycle until the requested amount is consumed.
module iter_shift_right #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt, dout_nxt, shifted;
  logic [SHW-1:0]   rem, rem_nxt, n_amt;
  logic             mode, mode_nxt;

  // Last step may be shorter than STEP so the total never exceeds shamt.
  always_comb begin
    n_amt   = (rem < STEP_W) ? rem : STEP_W;
    shifted = WIDTH'({{WIDTH{mode & work[WIDTH-1]}}, work} >> n_amt);
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    rem_nxt   = rem;
    mode_nxt  = mode;
    dout_nxt  = dout;
    case (state)
      IDLE: if (start) begin
        work_nxt = din;
        rem_nxt  = shamt;
        mode_nxt = arith;
        if (shamt == '0) begin
          state_nxt = DONE;
          dout_nxt  = din;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        rem_nxt  = rem - n_amt;
        if (rem == n_amt) begin
          state_nxt = DONE;
          dout_nxt  = shifted;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered decodes of the next state so they align with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      mode  <= 1'b0;
      dout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      rem   <= rem_nxt;
      mode  <= mode_nxt;
      dout  <= dout_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_iter_shift_right.sv
// Directed bench for iter_shift_right: STEP=1 and STEP=4 instances on a shared clock/reset.
module tb_iter_shift_right;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [31:0] din = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] dout1, dout4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  iter_shift_right #(.WIDTH(32), .SHW(5), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .din(din), .shamt(shamt), .arith(arith),
    .busy(busy1), .done(done1), .dout(dout1)
  );

  iter_shift_right #(.WIDTH(32), .SHW(5), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start4), .din(din), .shamt(shamt), .arith(arith),
    .busy(busy4), .done(done4), .dout(dout4)
  );

  typedef struct {
    bit          step4;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] exp_dout;
    int          exp_edges;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one request and follow it to done, checking latency, busy span and result.
  task automatic run_op(input vec_t v, input int idx);
    int   edges, busy_cnt;
    logic got;
    logic [31:0] hold;
    @(negedge clk);
    din = v.din; shamt = v.shamt; arith = v.arith;
    if (v.step4) start4 = 1'b1; else start1 = 1'b1;
    edges = 0; busy_cnt = 0; got = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clk); #1;
      start1 = 1'b0; start4 = 1'b0;
      edges++;
      if (v.step4 ? busy4 : busy1) busy_cnt++;
      if (v.step4 ? done4 : done1) got = 1'b1;
    end
    check($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d edges", idx), 32'(edges), 32'(v.exp_edges));
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt), 32'(v.exp_edges));
    hold = v.step4 ? dout4 : dout1;
    check($sformatf("v%0d dout", idx), hold, v.exp_dout);
    @(posedge clk); #1;
    check($sformatf("v%0d done_clear", idx), 32'(v.step4 ? done4 : done1), 32'd0);
    check($sformatf("v%0d busy_clear", idx), 32'(v.step4 ? busy4 : busy1), 32'd0);
    check($sformatf("v%0d dout_hold", idx), v.step4 ? dout4 : dout1, hold);
  endtask

  vec_t vecs[$];

  initial begin
    int pulses;
    vecs.push_back('{1'b0, 32'h80000000, 5'd4,  1'b0, 32'h08000000, 5});
    vecs.push_back('{1'b0, 32'h80000000, 5'd4,  1'b1, 32'hF8000000, 5});
    vecs.push_back('{1'b0, 32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, 32});
    vecs.push_back('{1'b0, 32'h12345678, 5'd0,  1'b0, 32'h12345678, 1});
    vecs.push_back('{1'b0, 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 32});
    vecs.push_back('{1'b0, 32'h80000000, 5'd31, 1'b0, 32'h00000001, 32});
    vecs.push_back('{1'b0, 32'hA5A5A5A5, 5'd8,  1'b1, 32'hFFA5A5A5, 9});
    vecs.push_back('{1'b0, 32'h0000FFFF, 5'd16, 1'b0, 32'h00000000, 17});
    vecs.push_back('{1'b1, 32'hF0000000, 5'd7,  1'b0, 32'h01E00000, 3});
    vecs.push_back('{1'b1, 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 9});
    vecs.push_back('{1'b1, 32'h80000000, 5'd4,  1'b1, 32'hF8000000, 2});
    vecs.push_back('{1'b1, 32'h12345678, 5'd0,  1'b1, 32'h12345678, 1});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst dout", dout1, 32'd0);
    check("rst dout4", dout4, 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], i);

    // Start held high through SHIFT and DONE with a different operand
    @(negedge clk);
    din = 32'h80000000; shamt = 5'd4; arith = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    din = 32'hFFFFFFFF; shamt = 5'd1; arith = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done1) begin pulses++; start1 = 1'b0; end
    end
    start1 = 1'b0;
    check("busy_start pulses", 32'(pulses), 32'd1);
    check("busy_start dout", dout1, 32'h08000000);

    // Asynchronous reset two cycles into a long operation
    @(negedge clk);
    din = 32'hFFFF0000; shamt = 5'd20; arith = 1'b1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("midrst busy", 32'(busy1), 32'd0);
    check("midrst done", 32'(done1), 32'd0);
    check("midrst dout", dout1, 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done1 || busy1) pulses++;
    end
    check("post_rst quiet", 32'(pulses), 32'd0);
    check("post_rst dout", dout1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
